// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared definitions for the VC weighted round-robin scheduler: default
// widths, destination bit, VC codes and the reset weight.
package vc_wrr_scheduler_pkg;

  localparam int SCHED_DATA_W         = 6;
  localparam int SCHED_WEIGHT_W       = 3;
  localparam int SCHED_DEST_BIT       = 4;
  localparam int SCHED_DEFAULT_WEIGHT = 1;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

  function automatic vc_e other_vc(input vc_e v);
    return (v == VC0) ? VC1 : VC0;
  endfunction

endpackage

// File: rtl/vc_wrr_scheduler_if.sv
// Bundle between the scheduler and its environment: VC FIFO heads/pops,
// D FIFO status/pushes, configuration and status.
interface vc_wrr_scheduler_if
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int DATA_W   = SCHED_DATA_W,
  parameter int WEIGHT_W = SCHED_WEIGHT_W
);

  logic                enable;
  logic [WEIGHT_W-1:0] weight_vc0;
  logic [WEIGHT_W-1:0] weight_vc1;
  logic                vc0_empty;
  logic                vc1_empty;
  logic [DATA_W-1:0]   vc0_data;
  logic [DATA_W-1:0]   vc1_data;
  logic                d0_almost_full;
  logic                d1_almost_full;
  logic                vc0_pop;
  logic                vc1_pop;
  logic                d0_push;
  logic                d1_push;
  logic [DATA_W-1:0]   data_out;
  logic                cur_vc;
  logic                stall;

  // Environment side: drives FIFO status and configuration.
  modport master (
    output enable, weight_vc0, weight_vc1,
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out, cur_vc, stall
  );

  // Scheduler side.
  modport slave (
    input  enable, weight_vc0, weight_vc1,
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out, cur_vc, stall
  );

endinterface

// File: rtl/vc_wrr_scheduler_credit.sv
// Credit counter for the round-robin pointer: load wins over decrement,
// decrement saturates at zero, zero/one detect feed the grant logic.
module wrr_credit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_one
);

  logic [WIDTH-1:0] r_credit;

  // Load a fresh credit or spend one; never wrap below zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit <= '0;
    end else if (i_load) begin
      r_credit <= i_load_val;
    end else if (i_dec && (r_credit != '0)) begin
      r_credit <= r_credit - WIDTH'(1);
    end
  end

  assign o_zero = (r_credit == '0);
  assign o_one  = (r_credit == WIDTH'(1));

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin between VC0/VC1 heads toward D0/D1. One grant per
// cycle at most; the pop is combinational, the push is one cycle later.
//
//   r_ptr | meaning
//   VC0   | VC0 owns the remaining credit
//   VC1   | VC1 owns the remaining credit
//
// Credit 0 only occurs out of reset and is treated as "exhausted", so the
// current VC reloads its own weight and is served.
module vc_wrr_scheduler
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int DATA_W   = SCHED_DATA_W,
  parameter int WEIGHT_W = SCHED_WEIGHT_W,
  parameter int DEST_BIT = SCHED_DEST_BIT
) (
  input logic               clk,
  input logic               reset,
  vc_wrr_scheduler_if.slave bus
);

  logic [WEIGHT_W-1:0] r_w0;
  logic [WEIGHT_W-1:0] r_w1;
  vc_e                 r_ptr;
  logic                r_d0_push;
  logic                r_d1_push;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_stall;

  logic                w_credit_zero;
  logic                w_credit_one;
  logic                w_blk0;
  logic                w_blk1;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_cur_elig;
  logic                w_oth_elig;
  logic [WEIGHT_W-1:0] w_w_cur;
  logic [WEIGHT_W-1:0] w_w_oth;
  logic                w_gnt;
  vc_e                 w_gnt_vc;
  vc_e                 w_ptr_nxt;
  logic                w_load;
  logic                w_dec;
  logic [WEIGHT_W-1:0] w_load_val;
  logic [DATA_W-1:0]   w_gnt_data;
  logic                w_gnt_dest;

  // A head is blocked when the D FIFO it targets is almost full.
  assign w_blk0  = bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
  assign w_blk1  = bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full;
  assign w_elig0 = bus.enable & ~bus.vc0_empty & ~w_blk0;
  assign w_elig1 = bus.enable & ~bus.vc1_empty & ~w_blk1;

  assign w_cur_elig = (r_ptr == VC0) ? w_elig0 : w_elig1;
  assign w_oth_elig = (r_ptr == VC0) ? w_elig1 : w_elig0;
  assign w_w_cur    = (r_ptr == VC0) ? r_w0 : r_w1;
  assign w_w_oth    = (r_ptr == VC0) ? r_w1 : r_w0;

  // Grant selection and the resulting pointer/credit update.
  always_comb begin
    w_gnt      = 1'b0;
    w_gnt_vc   = r_ptr;
    w_ptr_nxt  = r_ptr;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = '0;
    if (w_cur_elig) begin
      w_gnt    = 1'b1;
      w_gnt_vc = r_ptr;
      if (w_credit_one || (w_credit_zero && (w_w_cur == WEIGHT_W'(1)))) begin
        // Last credit spent: hand the pointer to the other VC.
        w_load     = 1'b1;
        w_load_val = w_w_oth;
        w_ptr_nxt  = other_vc(r_ptr);
      end else if (w_credit_zero) begin
        w_load     = 1'b1;
        w_load_val = w_w_cur - WEIGHT_W'(1);
      end else begin
        w_dec = 1'b1;
      end
    end else if (w_oth_elig) begin
      // Work-conserving switch; the other VC starts spending its own weight.
      w_gnt    = 1'b1;
      w_gnt_vc = other_vc(r_ptr);
      w_load   = 1'b1;
      if (w_w_oth == WEIGHT_W'(1)) begin
        w_load_val = w_w_cur;
        w_ptr_nxt  = r_ptr;
      end else begin
        w_load_val = w_w_oth - WEIGHT_W'(1);
        w_ptr_nxt  = other_vc(r_ptr);
      end
    end
  end

  assign w_gnt_data = (w_gnt_vc == VC1) ? bus.vc1_data : bus.vc0_data;
  assign w_gnt_dest = w_gnt_data[DEST_BIT];

  wrr_credit_counter #(
    .WIDTH (WEIGHT_W)
  ) u_credit (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_credit_zero),
    .o_one      (w_credit_one)
  );

  // Weights follow the inputs only while scheduling is disabled; 0 means 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w0 <= WEIGHT_W'(SCHED_DEFAULT_WEIGHT);
      r_w1 <= WEIGHT_W'(SCHED_DEFAULT_WEIGHT);
    end else if (!bus.enable) begin
      r_w0 <= (bus.weight_vc0 == '0) ? WEIGHT_W'(1) : bus.weight_vc0;
      r_w1 <= (bus.weight_vc1 == '0) ? WEIGHT_W'(1) : bus.weight_vc1;
    end
  end

  // Registered push/data/status; the granted word lands one cycle after its pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr      <= VC0;
      r_d0_push  <= 1'b0;
      r_d1_push  <= 1'b0;
      r_data_out <= '0;
      r_stall    <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_d0_push <= w_gnt & ~w_gnt_dest;
      r_d1_push <= w_gnt & w_gnt_dest;
      if (w_gnt) begin
        r_data_out <= w_gnt_data;
      end
      r_stall <= bus.enable & (~bus.vc0_empty | ~bus.vc1_empty) & ~w_gnt;
    end
  end

  // Pops are gated by reset so an asserted reset kills them immediately.
  assign bus.vc0_pop  = reset & w_gnt & (w_gnt_vc == VC0);
  assign bus.vc1_pop  = reset & w_gnt & (w_gnt_vc == VC1);
  assign bus.d0_push  = r_d0_push;
  assign bus.d1_push  = r_d1_push;
  assign bus.data_out = r_data_out;
  assign bus.cur_vc   = r_ptr;
  assign bus.stall    = r_stall;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: VC FIFOs are queues, a credit-based model of
// the weighted round-robin rules predicts pops, pushes and status each cycle.
module tb_vc_wrr_scheduler;

  localparam int DW   = 6;
  localparam int WW   = 3;
  localparam int DEST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vc_wrr_scheduler_if #(.DATA_W(DW), .WEIGHT_W(WW)) bus();

  vc_wrr_scheduler #(.DATA_W(DW), .WEIGHT_W(WW), .DEST_BIT(DEST)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit en;
  int w0in, w1in;
  bit af0, af1;

  int            m_ptr, m_credit;
  int            m_w[2];
  bit            m_d0, m_d1, m_stall;
  logic [DW-1:0] m_data;
  int            pop_log[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_credit = 0;
    m_w[0] = 1; m_w[1] = 1;
    m_d0 = 0; m_d1 = 0; m_stall = 0; m_data = '0;
  endtask

  task automatic drive();
    bus.enable         = en;
    bus.weight_vc0     = WW'(w0in);
    bus.weight_vc1     = WW'(w1in);
    bus.vc0_empty      = (q0.size() == 0);
    bus.vc1_empty      = (q1.size() == 0);
    bus.vc0_data       = (q0.size() != 0) ? q0[0] : '0;
    bus.vc1_data       = (q1.size() != 0) ? q1[0] : '0;
    bus.d0_almost_full = af0;
    bus.d1_almost_full = af1;
  endtask

  function automatic bit elig(input int v);
    logic [DW-1:0] h;
    if (!en) return 1'b0;
    if (v == 0) begin
      if (q0.size() == 0) return 1'b0;
      h = q0[0];
    end else begin
      if (q1.size() == 0) return 1'b0;
      h = q1[0];
    end
    return h[DEST] ? !af1 : !af0;
  endfunction

  // One clock: present inputs, check at negedge, advance model at posedge.
  task automatic cyc();
    bit e[2];
    bit gnt;
    int g, nptr, nc, c;
    logic [DW-1:0] head;
    drive();
    @(negedge clk);
    e[0] = elig(0);
    e[1] = elig(1);
    gnt = 0; g = 0; nptr = m_ptr; nc = m_credit;
    if (e[m_ptr]) begin
      gnt = 1; g = m_ptr;
      c = ((m_credit == 0) ? m_w[m_ptr] : m_credit) - 1;
      if (c == 0) begin nptr = 1 - m_ptr; nc = m_w[1 - m_ptr]; end
      else begin nptr = m_ptr; nc = c; end
    end else if (e[1 - m_ptr]) begin
      gnt = 1; g = 1 - m_ptr;
      c = m_w[g] - 1;
      if (c == 0) begin nptr = m_ptr; nc = m_w[m_ptr]; end
      else begin nptr = g; nc = c; end
    end
    chk("vc0_pop", bus.vc0_pop, int'(gnt && g == 0));
    chk("vc1_pop", bus.vc1_pop, int'(gnt && g == 1));
    chk("d0_push", bus.d0_push, m_d0);
    chk("d1_push", bus.d1_push, m_d1);
    if (m_d0 || m_d1) chk("data_out", bus.data_out, m_data);
    chk("cur_vc", bus.cur_vc, m_ptr);
    chk("stall", bus.stall, m_stall);
    if (bus.vc0_pop) pop_log.push_back(0);
    if (bus.vc1_pop) pop_log.push_back(1);
    @(posedge clk);
    m_stall = en && (q0.size() != 0 || q1.size() != 0) && !gnt;
    m_d0 = 0; m_d1 = 0;
    if (gnt) begin
      if (g == 0) head = q0.pop_front();
      else        head = q1.pop_front();
      m_data = head;
      m_d0 = !head[DEST];
      m_d1 = head[DEST];
    end
    m_ptr = nptr; m_credit = nc;
    if (!en) begin
      m_w[0] = (w0in == 0) ? 1 : w0in;
      m_w[1] = (w1in == 0) ? 1 : w1in;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    en = 0; w0in = 1; w1in = 1; af0 = 0; af1 = 0;
    model_reset();
    drive();
    #1;
    // Reset values
    chk("rst_vc0_pop", bus.vc0_pop, 0);
    chk("rst_vc1_pop", bus.vc1_pop, 0);
    chk("rst_d0_push", bus.d0_push, 0);
    chk("rst_d1_push", bus.d1_push, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_cur_vc", bus.cur_vc, 0);
    chk("rst_stall", bus.stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Weights 3/1, both VCs loaded: order 0,0,0,1,0,0,0,1
    en = 0; w0in = 3; w1in = 1;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'(i));
      q1.push_back(DW'(6'h10 | i));
    end
    cyc();
    en = 1;
    pop_log.delete();
    for (int i = 0; i < 8; i++) cyc();
    begin
      int exp_order[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      chk("s1_pop_count", pop_log.size(), 8);
      for (int i = 0; i < 8 && i < pop_log.size(); i++)
        chk($sformatf("s1_order_%0d", i), pop_log[i], exp_order[i]);
    end
    for (int i = 0; i < 12; i++) cyc();

    // Destination routing by bit 4
    q0.push_back(6'h15);
    cyc();
    chk("s4_d1_push", bus.d1_push, 1);
    chk("s4_d0_push_lo", bus.d0_push, 0);
    chk("s4_data_15", bus.data_out, 6'h15);
    q0.push_back(6'h05);
    cyc();
    chk("s4_d0_push", bus.d0_push, 1);
    chk("s4_data_05", bus.data_out, 6'h05);
    cyc();

    // VC0 empty, VC1 four words, weights 3/3: work-conserving
    do_reset();
    en = 0; w0in = 3; w1in = 3;
    cyc();
    en = 1;
    for (int i = 0; i < 4; i++) q1.push_back(DW'(6'h20 + i));
    pop_log.delete();
    for (int i = 0; i < 4; i++) cyc();
    chk("s2_pop_count", pop_log.size(), 4);
    for (int i = 0; i < pop_log.size(); i++) chk("s2_vc1_only", pop_log[i], 1);
    chk("s2_cur_vc", bus.cur_vc, 1);
    cyc();

    // VC0 blocked by d1_almost_full, VC1 drains, then stall
    do_reset();
    en = 0; w0in = 2; w1in = 2;
    cyc();
    en = 1; af1 = 1;
    q0.push_back(6'h12); q0.push_back(6'h1A);
    q1.push_back(6'h03); q1.push_back(6'h07);
    pop_log.delete();
    for (int i = 0; i < 3; i++) cyc();
    chk("s3_pops", pop_log.size(), 2);
    chk("s3_stall", bus.stall, 1);
    cyc();
    af1 = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("s3_empty_stall", bus.stall, 0);

    // Weight 0 latched behaves as 1; changes while enabled are ignored
    do_reset();
    en = 0; w0in = 0; w1in = 0;
    cyc();
    en = 1; w0in = 7; w1in = 2;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(DW'(i));
      q1.push_back(DW'(6'h30 + i));
    end
    pop_log.delete();
    for (int i = 0; i < 4; i++) cyc();
    begin
      int exp_alt[4] = '{0, 1, 0, 1};
      chk("s5_pop_count", pop_log.size(), 4);
      for (int i = 0; i < 4 && i < pop_log.size(); i++)
        chk($sformatf("s5_order_%0d", i), pop_log[i], exp_alt[i]);
    end

    // Reset between pop and push
    q0.push_back(6'h01); q1.push_back(6'h02);
    drive();
    @(negedge clk);
    chk("s6_pop_before", int'(bus.vc0_pop | bus.vc1_pop), 1);
    rst_n = 1'b0;
    #1;
    chk("s6_vc0_pop_drop", bus.vc0_pop, 0);
    chk("s6_vc1_pop_drop", bus.vc1_pop, 0);
    @(posedge clk); #1;
    chk("s6_d0_push", bus.d0_push, 0);
    chk("s6_d1_push", bus.d1_push, 0);
    chk("s6_cur_vc", bus.cur_vc, 0);
    chk("s6_stall", bus.stall, 0);
    do_reset();
    en = 0; w0in = 2; w1in = 2;
    q0.push_back(6'h11); q1.push_back(6'h22);
    cyc();
    en = 1;
    pop_log.delete();
    cyc();
    chk("s6_first_vc0", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      af0 = ($urandom_range(0, 3) == 0);
      af1 = ($urandom_range(0, 3) == 0);
      w0in = $urandom_range(0, 7);
      w1in = $urandom_range(0, 7);
      if (q0.size() < 16 && $urandom_range(0, 1) == 1) q0.push_back(DW'($urandom));
      if (q1.size() < 16 && $urandom_range(0, 1) == 1) q1.push_back(DW'($urandom));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
